// File: rtl/vga_bounce_pattern_gen.sv
// vga_bounce_pattern_gen
//   Pixel source that feeds the VGA timing generator's 24-bit Data input.
//   It draws colour bars, a one-pixel white border around the active area, and a solid
//   box that bounces around the active area. The box moves at most once per FRAME_DIV
//   frames, and the frame boundary is the falling edge of vga_vs.
//   The output is registered, so data at clock t+1 reflects pix_* at clock t.
//
//   Optional build macro: GRID_OVERLAY_EN. When it is defined, pixels on every 32nd
//   column or row turn grey (808080). The grid sits below the box and the border and
//   above the bars.
//
// Ports
//   sys_clk     in   1   pixel clock
//   rst_n       in   1   asynchronous, active-low reset
//   vga_vs      in   1   vertical sync, active-low pulse
//   pix_de      in   1   active-area enable
//   pix_x       in   12  active-area column
//   pix_y       in   12  active-area row
//   pause       in   1   freezes box motion; drawing continues
//   data        out  24  pixel colour {R,G,B}
//   frame_tick  out  1   one-clock pulse per vga_vs falling edge
//
// Direction encoding (per axis)
//   state   | meaning
//   DIR_FWD | moving toward larger coordinates (RIGHT / DOWN)
//   DIR_REV | moving toward zero (LEFT / UP)

module vga_bounce_pattern_gen #(
    parameter int          H_ACT     = 640,
    parameter int          V_ACT     = 480,
    parameter int          BOX_W     = 64,
    parameter int          BOX_H     = 48,
    parameter int          STEP      = 2,
    parameter int          FRAME_DIV = 1,
    parameter logic [23:0] BOX_COLOR = 24'hFFFF00
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic        vga_vs,
    input  logic        pix_de,
    input  logic [11:0] pix_x,
    input  logic [11:0] pix_y,
    input  logic        pause,
    output logic [23:0] data,
    output logic        frame_tick
);

    typedef enum logic {DIR_FWD = 1'b0, DIR_REV = 1'b1} dir_t;

    localparam int              FCW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FCW-1:0]  FCNT_LAST = FCW'(FRAME_DIV - 1);
    localparam logic [12:0]     X_MAX     = 13'(H_ACT - BOX_W);
    localparam logic [12:0]     Y_MAX     = 13'(V_ACT - BOX_H);
    localparam logic [12:0]     STEP13    = 13'(STEP);
    localparam int              BAR_W     = H_ACT / 8;

    logic           vs_q, vs_d;
    logic           frame_tick_q, frame_tick_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic [11:0]    box_x_q, box_x_d, box_y_q, box_y_d;
    dir_t           dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [23:0]    data_q, data_d;

    logic           move;
    logic [12:0]    x_sum, y_sum;
    logic [12:0]    box_x_end, box_y_end;
    logic           in_box, on_border;
    logic [2:0]     bar_idx;
    logic [23:0]    bar_color;

    // Frame detect, frame divider and box motion.
    always_comb begin
        vs_d         = vga_vs;
        frame_tick_d = vs_q & ~vga_vs;
        frame_cnt_d  = frame_cnt_q;
        box_x_d      = box_x_q;
        box_y_d      = box_y_q;
        dir_x_d      = dir_x_q;
        dir_y_d      = dir_y_q;
        x_sum        = {1'b0, box_x_q} + STEP13;
        y_sum        = {1'b0, box_y_q} + STEP13;
        move         = frame_tick_q && (frame_cnt_q == FCNT_LAST);

        // The divider keeps counting while paused so that the move cadence does not drift.
        if (frame_tick_q) begin
            frame_cnt_d = (frame_cnt_q == FCNT_LAST) ? '0 : frame_cnt_q + 1'b1;
        end

        if (move && !pause) begin
            // The edge is clamped rather than overshot, so the box never leaves the active area.
            if (dir_x_q == DIR_FWD) begin
                if (x_sum >= X_MAX) begin
                    box_x_d = X_MAX[11:0];
                    dir_x_d = DIR_REV;
                end else begin
                    box_x_d = x_sum[11:0];
                end
            end else begin
                if ({1'b0, box_x_q} <= STEP13) begin
                    box_x_d = '0;
                    dir_x_d = DIR_FWD;
                end else begin
                    box_x_d = box_x_q - STEP13[11:0];
                end
            end

            if (dir_y_q == DIR_FWD) begin
                if (y_sum >= Y_MAX) begin
                    box_y_d = Y_MAX[11:0];
                    dir_y_d = DIR_REV;
                end else begin
                    box_y_d = y_sum[11:0];
                end
            end else begin
                if ({1'b0, box_y_q} <= STEP13) begin
                    box_y_d = '0;
                    dir_y_d = DIR_FWD;
                end else begin
                    box_y_d = box_y_q - STEP13[11:0];
                end
            end
        end
    end

    // Pixel colour selection.
    always_comb begin
        box_x_end = {1'b0, box_x_q} + 13'(BOX_W);
        box_y_end = {1'b0, box_y_q} + 13'(BOX_H);
        in_box    = (pix_x >= box_x_q) && ({1'b0, pix_x} < box_x_end) &&
                    (pix_y >= box_y_q) && ({1'b0, pix_y} < box_y_end);
        on_border = (pix_x == 12'd0) || (pix_x == 12'(H_ACT - 1)) ||
                    (pix_y == 12'd0) || (pix_y == 12'(V_ACT - 1));

        // The bar index comes from threshold compares, which avoids a divider.
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (pix_x >= 12'(k * BAR_W)) bar_idx = 3'(k);
        end

        case (bar_idx)
            3'd0:    bar_color = 24'hFFFFFF;
            3'd1:    bar_color = 24'hFFFF00;
            3'd2:    bar_color = 24'h00FFFF;
            3'd3:    bar_color = 24'h00FF00;
            3'd4:    bar_color = 24'hFF00FF;
            3'd5:    bar_color = 24'hFF0000;
            3'd6:    bar_color = 24'h0000FF;
            default: bar_color = 24'h000000;
        endcase

        if (!pix_de)        data_d = 24'h000000;
        else if (in_box)    data_d = BOX_COLOR;
        else if (on_border) data_d = 24'hFFFFFF;
`ifdef GRID_OVERLAY_EN
        else if ((pix_x[4:0] == 5'd0) || (pix_y[4:0] == 5'd0)) data_d = 24'h808080;
`endif
        else                data_d = bar_color;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q         <= 1'b1;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= '0;
            box_x_q      <= '0;
            box_y_q      <= '0;
            dir_x_q      <= DIR_FWD;
            dir_y_q      <= DIR_FWD;
            data_q       <= '0;
        end else begin
            vs_q         <= vs_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
            box_x_q      <= box_x_d;
            box_y_q      <= box_y_d;
            dir_x_q      <= dir_x_d;
            dir_y_q      <= dir_y_d;
            data_q       <= data_d;
        end
    end

    assign data       = data_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_bounce_pattern_gen.sv
// Testbench for vga_bounce_pattern_gen. Two instances share the same stimulus:
// dut0 uses the default FRAME_DIV=1 and dut3 uses FRAME_DIV=3.
// Optional build macro checked here: GRID_OVERLAY_EN.

module tb_vga_bounce_pattern_gen;

    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
    localparam int BOX_W = 64;
    localparam int BOX_H = 48;
    localparam int STEP  = 2;
    localparam int X_MAX = H_ACT - BOX_W;
    localparam int Y_MAX = V_ACT - BOX_H;

    logic        sys_clk = 1'b0;
    logic        rst_n;
    logic        vga_vs;
    logic        pix_de;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        pause;
    logic [23:0] data0, data3;
    logic        tick0, tick3;

    always #5 sys_clk = ~sys_clk;

    vga_bounce_pattern_gen #(.FRAME_DIV(1)) dut0 (
        .sys_clk(sys_clk), .rst_n(rst_n), .vga_vs(vga_vs), .pix_de(pix_de),
        .pix_x(pix_x), .pix_y(pix_y), .pause(pause), .data(data0), .frame_tick(tick0)
    );

    vga_bounce_pattern_gen #(.FRAME_DIV(3)) dut3 (
        .sys_clk(sys_clk), .rst_n(rst_n), .vga_vs(vga_vs), .pix_de(pix_de),
        .pix_x(pix_x), .pix_y(pix_y), .pause(pause), .data(data3), .frame_tick(tick3)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state: index 0 models dut0 and index 1 models dut3. The right and down
    // flags are 1 while the box moves toward larger coordinates.
    int mbx[2], mby[2], mright[2], mdown[2], mcnt[2];
    int mdiv[2];
    logic [23:0] bars[8];

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mbx[i] = 0; mby[i] = 0; mright[i] = 1; mdown[i] = 1; mcnt[i] = 0;
        end
    endtask

    task automatic model_frame(input bit p);
        for (int i = 0; i < 2; i++) begin
            mcnt[i]++;
            if (mcnt[i] == mdiv[i]) begin
                mcnt[i] = 0;
                if (!p) begin
                    if (mright[i] != 0) begin
                        if (mbx[i] + STEP >= X_MAX) begin mbx[i] = X_MAX; mright[i] = 0; end
                        else mbx[i] += STEP;
                    end else begin
                        if (mbx[i] <= STEP) begin mbx[i] = 0; mright[i] = 1; end
                        else mbx[i] -= STEP;
                    end
                    if (mdown[i] != 0) begin
                        if (mby[i] + STEP >= Y_MAX) begin mby[i] = Y_MAX; mdown[i] = 0; end
                        else mby[i] += STEP;
                    end else begin
                        if (mby[i] <= STEP) begin mby[i] = 0; mdown[i] = 1; end
                        else mby[i] -= STEP;
                    end
                end
            end
        end
    endtask

    function automatic logic [23:0] ref_pix(input int x, input int y, input int bx,
                                            input int by, input bit de);
        if (!de) return 24'h000000;
        if (x >= bx && x < bx + BOX_W && y >= by && y < by + BOX_H) return 24'hFFFF00;
        if (x == 0 || x == H_ACT - 1 || y == 0 || y == V_ACT - 1) return 24'hFFFFFF;
`ifdef GRID_OVERLAY_EN
        if (x % 32 == 0 || y % 32 == 0) return 24'h808080;
`endif
        return bars[x / (H_ACT / 8)];
    endfunction

    task automatic check_pos(input string tag);
        chk({tag, "_x0"}, 24'(dut0.box_x_q), 24'(mbx[0]));
        chk({tag, "_y0"}, 24'(dut0.box_y_q), 24'(mby[0]));
        chk({tag, "_x3"}, 24'(dut3.box_x_q), 24'(mbx[1]));
        chk({tag, "_y3"}, 24'(dut3.box_y_q), 24'(mby[1]));
    endtask

    task automatic probe(input string tag, input int x, input int y, input bit de);
        pix_de = de;
        pix_x  = 12'(x);
        pix_y  = 12'(y);
        step();
        chk({tag, "_d0"}, data0, ref_pix(x, y, mbx[0], mby[0], de));
        chk({tag, "_d3"}, data3, ref_pix(x, y, mbx[1], mby[1], de));
        pix_de = 1'b0;
    endtask

    task automatic vs_pulse(input bit p);
        pause  = p;
        vga_vs = 1'b0;
        step();
        chk("tick_hi0", 24'(tick0), 24'd1);
        chk("tick_hi3", 24'(tick3), 24'd1);
        model_frame(p);
        step();
        chk("tick_lo0", 24'(tick0), 24'd0);
        check_pos("move");
        vga_vs = 1'b1;
        step();
        step();
        pause = 1'b0;
    endtask

    task automatic rand_probe();
        int x, y;
        if ($urandom_range(0, 1) == 1) begin
            x = mbx[0] + $urandom_range(0, BOX_W + 1) - 1;
            y = mby[0] + $urandom_range(0, BOX_H + 1) - 1;
            if (x < 0) x = 0;
            if (x > H_ACT - 1) x = H_ACT - 1;
            if (y < 0) y = 0;
            if (y > V_ACT - 1) y = V_ACT - 1;
        end else begin
            x = $urandom_range(0, H_ACT - 1);
            y = $urandom_range(0, V_ACT - 1);
        end
        probe("rand_pix", x, y, $urandom_range(0, 7) != 0);
    endtask

    initial begin
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        mdiv = '{1, 3};
        model_reset();

        // Reset held with pix_de high.
        rst_n = 1'b0; vga_vs = 1'b1; pause = 1'b0;
        pix_de = 1'b1; pix_x = 12'd10; pix_y = 12'd10;
        step(); step(); step();
        chk("rst_data0", data0, 24'h0);
        chk("rst_data3", data3, 24'h0);
        chk("rst_tick0", 24'(tick0), 24'd0);
        rst_n = 1'b1;
        pix_de = 1'b0;
        step();
        check_pos("rst_pos");

        // Directed pixels with the box at (0,0).
        probe("box_10_10",  10, 10, 1'b1);
        probe("bar1_100",  100, 200, 1'b1);
        probe("border_x0",   0, 300, 1'b1);
        probe("px_96_200",  96, 200, 1'b1);
        probe("border_br", 639, 479, 1'b1);
        probe("bar7",      600, 300, 1'b1);
        probe("de_low",     10, 10, 1'b0);

        // One frame, then three paused frames.
        vs_pulse(1'b0);
        chk("first_x", 24'(dut0.box_x_q), 24'd2);
        chk("first_y", 24'(dut0.box_y_q), 24'd2);
        repeat (3) vs_pulse(1'b1);
        chk("pause_x", 24'(dut0.box_x_q), 24'd2);

        // Run unpaused until the box reaches x=574 moving right, then cross the right edge.
        for (int n = 0; n < 400 && !(mbx[0] == 574 && mright[0] == 1); n++) begin
            vs_pulse(1'b0);
            if (n % 16 == 0) rand_probe();
        end
        chk("reach_574", 24'(dut0.box_x_q), 24'd574);
        vs_pulse(1'b0);
        chk("edge_576", 24'(dut0.box_x_q), 24'd576);
        vs_pulse(1'b0);
        chk("back_574", 24'(dut0.box_x_q), 24'd574);

        // Randomized frames with occasional pause.
        repeat (150) begin
            rand_probe();
            rand_probe();
            vs_pulse($urandom_range(0, 5) == 0);
        end

        // Reset mid-frame while drawing.
        pix_de = 1'b1;
        pix_x = 12'(mbx[0] + 1);
        pix_y = 12'(mby[0] + 1);
        step();
        chk("pre_rst", data0, 24'hFFFF00);
        rst_n = 1'b0;
        #1;
        chk("midrst_d0", data0, 24'h0);
        chk("midrst_d3", data3, 24'h0);
        model_reset();
        check_pos("midrst_pos");
        step();
        rst_n = 1'b1;
        pix_de = 1'b0;
        step();
        probe("post_rst", 10, 10, 1'b1);
        vs_pulse(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
